// File: rtl/alu_seq.sv
// Signed saturating ALU with a start/busy/done handshake. Single-cycle ops load
// on the accept edge. The multiply runs as a WIDTH-iteration shift-add on operand magnitudes.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic signed [EW-1:0] MAX_E = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_E = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [PW-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, MUL} state_t;
    typedef enum logic [2:0] {
        OP_PASSA = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_XOR   = 3'b100,
        OP_ABS   = 3'b101,
        OP_MUL   = 3'b110,
        OP_PASSB = 3'b111
    } op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic signed [EW-1:0] aExt, bExt, wide;
    logic                 satOp;
    logic [WIDTH-1:0]     aluRes;
    logic                 aluOvf;
    logic [WIDTH-1:0]     absA, absB;
    logic [PW-1:0]        accNext;
    logic [WIDTH-1:0]     mulLow;
    logic [WIDTH-1:0]     mulRes;
    logic                 mulOvf;

    assign aExt = {{2{accum[WIDTH-1]}}, accum};
    assign bExt = {{2{data[WIDTH-1]}}, data};

    // Two guard bits keep add/sub/abs exact before clamping.
    always_comb begin
        wide  = '0;
        satOp = 1'b0;
        case (op_t'(opcode))
            OP_PASSA: wide = aExt;
            OP_ADD:   begin wide = aExt + bExt; satOp = 1'b1; end
            OP_SUB:   begin wide = aExt - bExt; satOp = 1'b1; end
            OP_AND:   wide = aExt & bExt;
            OP_XOR:   wide = aExt ^ bExt;
            OP_ABS:   begin wide = accum[WIDTH-1] ? -aExt : aExt; satOp = 1'b1; end
            OP_PASSB: wide = bExt;
            default:  wide = '0;
        endcase
    end

    always_comb begin
        aluRes = wide[WIDTH-1:0];
        aluOvf = 1'b0;
        if (satOp && (wide > MAX_E)) begin
            aluRes = MAX_W;
            aluOvf = 1'b1;
        end else if (satOp && (wide < MIN_E)) begin
            aluRes = MIN_W;
            aluOvf = 1'b1;
        end
    end

    assign absA = accum[WIDTH-1] ? (~accum + WIDTH'(1)) : accum;
    assign absB = data[WIDTH-1]  ? (~data + WIDTH'(1))  : data;

    assign accNext = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mulLow  = accNext[WIDTH-1:0];

    // A negative result may reach exactly 2^(WIDTH-1) in magnitude without clamping.
    always_comb begin
        mulRes = mulLow;
        mulOvf = 1'b0;
        if (!neg_q) begin
            if (accNext > POS_LIM) begin
                mulRes = MAX_W;
                mulOvf = 1'b1;
            end
        end else if (accNext > NEG_LIM) begin
            mulRes = MIN_W;
            mulOvf = 1'b1;
        end else begin
            mulRes = ~mulLow + WIDTH'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_t'(opcode) == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, absA};
                        mplier_d = absB;
                        neg_d    = accum[WIDTH-1] ^ data[WIDTH-1];
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d = aluRes;
                        zero_d   = (aluRes == '0);
                        ovf_d    = aluOvf;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = accNext;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = mulRes;
                    zero_d   = (mulRes == '0);
                    ovf_d    = mulOvf;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign alu_out  = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == MUL);
    assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver predicts each result with plain integer
// arithmetic and its completion edge; the monitor checks every cycle against the queue.
module tb_alu_seq;

    localparam int W = 8;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    typedef struct {
        int           edgeNo;
        logic         isReset;
        logic [W-1:0] res;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] accum;
    logic [W-1:0] data;
    logic [W-1:0] alu_out;
    logic         zero;
    logic         overflow;
    logic         busy;
    logic         done;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mulAcc = 0;
    int   mulEnd = 0;
    logic synced = 1'b0;
    logic [W-1:0] heldRes = '0;
    logic heldZ = 1'b1;
    logic heldO = 1'b0;
    exp_t sbq[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opcode   (opcode),
        .accum    (accum),
        .data     (data),
        .alu_out  (alu_out),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: exact integer arithmetic, then clamp for saturating ops.
    function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic z, output logic o);
        longint sa, sb, r;
        logic satOp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        satOp = 1'b1;
        case (op)
            3'd0: begin r = sa; satOp = 1'b0; end
            3'd1: r = sa + sb;
            3'd2: r = sa - sb;
            3'd3: begin r = longint'(a & b); satOp = 1'b0; end
            3'd4: begin r = longint'(a ^ b); satOp = 1'b0; end
            3'd5: r = (sa < 0) ? -sa : sa;
            3'd6: r = sa * sb;
            default: begin r = sb; satOp = 1'b0; end
        endcase
        o = 1'b0;
        if (satOp && r > MAXV) begin
            r = MAXV;
            o = 1'b1;
        end else if (satOp && r < MINV) begin
            r = MINV;
            o = 1'b1;
        end
        res = W'(r);
        z = (res == '0);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk) #2;
    endtask

    task automatic applyReset();
        int r;
        exp_t e;
        r = cyc + 1;
        reset = 1'b1;
        start = 1'b0;
        while (sbq.size() > 0 && sbq[$].edgeNo >= r) void'(sbq.pop_back());
        e.edgeNo = r; e.isReset = 1'b1; e.res = '0; e.z = 1'b1; e.o = 1'b0;
        sbq.push_back(e);
        if (mulEnd > r) mulEnd = r;
        @(posedge clk) #2;
        reset = 1'b0;
    endtask

    // One start pulse; the op is accepted only if no multiply owns this edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int e0;
        exp_t e;
        e0 = cyc + 1;
        opcode = op;
        accum = a;
        data = b;
        start = 1'b1;
        if (e0 > mulEnd) begin
            refModel(op, a, b, e.res, e.z, e.o);
            e.isReset = 1'b0;
            if (op == 3'b110) begin
                mulAcc = e0;
                mulEnd = e0 + W;
                e.edgeNo = e0 + W;
            end else begin
                e.edgeNo = e0;
            end
            sbq.push_back(e);
        end
        @(posedge clk) #2;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic expDone;
        logic expBusy;
        expDone = 1'b0;
        while (sbq.size() > 0 && sbq[0].edgeNo < cyc) begin
            e = sbq.pop_front();
            checkOutput("lost_result", 32'd0, 32'd1);
        end
        if (sbq.size() > 0 && sbq[0].edgeNo == cyc) begin
            e = sbq.pop_front();
            if (e.isReset) synced = 1'b1;
            else expDone = 1'b1;
            heldRes = e.res;
            heldZ = e.z;
            heldO = e.o;
        end
        expBusy = (cyc >= mulAcc) && (cyc < mulEnd);
        if (synced) begin
            checkOutput("done", 32'(done), 32'(expDone));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("alu_out", 32'(alu_out), 32'(heldRes));
            checkOutput("zero", 32'(zero), 32'(heldZ));
            checkOutput("overflow", 32'(overflow), 32'(heldO));
        end
    end

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return {1'b1, {(W-1){1'b0}}};
            1: return {1'b0, {(W-1){1'b1}}};
            2: return '0;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opcode = '0;
        accum = '0;
        data = '0;
        applyReset();
        applyReset();
        idle(2);

        $display("[TB] saturating add/sub");
        applyStimulus(3'b001, 8'd100, 8'd50);
        idle(2);
        applyStimulus(3'b010, 8'h9C, 8'd50);
        applyStimulus(3'b010, 8'd5, 8'd5);
        idle(2);

        $display("[TB] multiply");
        applyStimulus(3'b110, 8'hFD, 8'd5);
        idle(W + 1);
        applyStimulus(3'b110, 8'd20, 8'd20);
        idle(W + 1);
        applyStimulus(3'b110, 8'h80, 8'h80);
        idle(W + 1);
        applyStimulus(3'b110, 8'h00, 8'hF0);
        idle(W + 1);

        $display("[TB] starts during multiply");
        applyStimulus(3'b110, 8'd6, 8'd7);
        idle(1);
        applyStimulus(3'b111, 8'h00, 8'h55);
        idle(5);
        applyStimulus(3'b111, 8'h00, 8'h55);
        applyStimulus(3'b000, 8'h11, 8'h00);
        idle(2);

        $display("[TB] reset aborts multiply, abs");
        applyStimulus(3'b110, 8'd9, 8'd9);
        idle(3);
        applyReset();
        idle(1);
        applyStimulus(3'b101, 8'h80, 8'h00);
        applyStimulus(3'b101, 8'hF6, 8'h00);
        idle(2);

        $display("[TB] logic ops");
        applyStimulus(3'b011, 8'hC3, 8'h5A);
        applyStimulus(3'b100, 8'hC3, 8'h5A);
        applyStimulus(3'b000, 8'hC3, 8'h5A);
        applyStimulus(3'b111, 8'hC3, 8'h5A);
        idle(2);

        $display("[TB] random sweep");
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 999) == 0) applyReset();
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(W + 3);
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised signed ALU and the next generation of the datapath ALU. It adds a generic operand width, saturating two's-complement arithmetic and a full-width multi-cycle signed multiplier. A start/busy/done handshake lets the controller issue one operation at a time. Registered flags report zero and overflow (saturation).

Parameters:
WIDTH, 8, operand/result width in bits; two's-complement signed; legal range 4..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only on an edge where busy=0
opcode  input  3  operation select, sampled on accept
accum  input  WIDTH  operand A, sampled on accept
data  input  WIDTH  operand B, sampled on accept
alu_out  output  WIDTH  registered result; holds until next completion
zero  output  1  registered; 1 when the loaded alu_out==0
overflow  output  1  registered; 1 when the loaded result was saturated
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse marking the edge a new result was loaded

Behaviour:
- Reset (sync, high): alu_out=0, zero=1, overflow=0, busy=0, done=0; FSM->IDLE, counter=0. Reset aborts any in-flight multiply; its result is never loaded.
- Saturation range: MIN=-2^(WIDTH-1), MAX=2^(WIDTH-1)-1. Saturating ops compute exactly at extended width, clamp to [MIN,MAX] and set overflow=1 iff clamped.
- Opcodes:
  - 000: A.
  - 001: saturating A+B.
  - 010: saturating A-B.
  - 011: A&B.
  - 100: A^B.
  - 101: |A|; |MIN| gives MAX with overflow=1.
  - 110: saturating signed A*B from the 2*WIDTH-bit exact product (multi-cycle).
  - 111: B.
  - Non-saturating ops load overflow=0.
- FSM has two states, IDLE and MUL.
- IDLE, start=1, opcode!=110: on that edge alu_out/zero/overflow load and done=1 for the following cycle. Latency is 1 edge. State stays IDLE, so back-to-back starts every cycle are legal.
- IDLE, start=1, opcode=110: on edge E0, capture |A|, |B|, result sign (A[msb]^B[msb]); clear the 2*WIDTH accumulator and counter; busy=1; ->MUL. No outputs change on E0.
- MUL: one shift-add iteration per edge (LSB of multiplier selects adding the shifted multiplicand); counter increments.
- MUL, iteration WIDTH (edge E0+WIDTH): apply sign (negate if set), saturate, load alu_out/zero/overflow, done=1, busy=0, ->IDLE. Multiply latency is exactly WIDTH edges after accept.
- busy is high for exactly WIDTH cycles, from after E0 through the cycle before done.
- start while busy=1: ignored, not queued. Operand or opcode changes during MUL have no effect.
- The edge that completes a multiply is also IDLE-capable only on the next edge. A start coinciding with the completion edge is ignored.
- done is low on every edge that does not load a result. alu_out, zero and overflow are held otherwise.
- Operands MIN*MIN: magnitude 2^(2*WIDTH-2) fits the accumulator; the result saturates to MAX with overflow=1.
- Zero product with a negative sign yields 0 (no negative zero); zero=1, overflow=0.

Test Plan:
WIDTH=8 for all scenarios.
1. Reset, then idle -> alu_out=0x00, zero=1, overflow=0, busy=0, done=0; start with opcode=001, A=100, B=50 -> next edge alu_out=0x7F, overflow=1, done pulse 1 cycle.
2. opcode=010, A=-100 (0x9C), B=50 -> alu_out=0x80, overflow=1. Then opcode=010, A=5, B=5 -> alu_out=0, zero=1, overflow=0. Issued on consecutive cycles, both complete with one done each.
3. opcode=110, A=-3 (0xFD), B=5 -> busy high 8 cycles, done exactly 8 edges after accept, alu_out=0xF1 (-15), overflow=0. Also A=20, B=20 -> 0x7F, overflow=1. Also A=B=0x80 -> 0x7F, overflow=1.
4. During a multiply of 6*7, pulse start with opcode=111, data=0x55 at cycles 2 and 8 (the completion edge) -> both ignored; alu_out=42 (0x2A); exactly one done pulse.
5. Assert reset at multiply cycle 4 -> next edge busy=0, alu_out=0, zero=1, no done pulse. Then opcode=101, A=0x80 -> alu_out=0x7F, overflow=1. Then A=0xF6 (-10) -> 0x0A.
6. opcode=011, 100, 000, 111 with A=0xC3, B=0x5A -> 0x42, 0x99, 0xC3, 0x5A; overflow=0 each; random sweep of all opcodes versus a saturating reference model, 10k ops.
